// File: rtl/ivl_uvm_parity_pkg.sv
// ivl_uvm_parity_pkg: shared parity helper, stored-word type and count-width rule for the parity FIFO (PARITY_FIFO_ERR_INJECT_EN aware)
package ivl_uvm_parity_pkg;
  localparam int PAR_MAX_W = 64;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);
  typedef logic [DEF_WIDTH:0] word_t;
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ivl_uvm_even_parity_gen.sv
// ivl_uvm_even_parity_gen: combinational {even parity, data} word builder
module ivl_uvm_even_parity_gen
  import ivl_uvm_parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH:0]   word
);
  assign word = {even_par(PAR_MAX_W'(data)), data};
endmodule

// File: rtl/ivl_uvm_parity_fifo.sv
// ivl_uvm_parity_fifo: parity-appending sync FIFO with read-side check; PARITY_FIFO_ERR_INJECT_EN adds err_inject
module ivl_uvm_parity_fifo
  import ivl_uvm_parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wn,
  input  logic [WIDTH-1:0]             din,
`ifdef PARITY_FIFO_ERR_INJECT_EN
  input  logic                         err_inject,
`endif
  input  logic                         rn,
  output logic [WIDTH:0]               dout,
  output logic                         dout_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [WIDTH:0]  gen_word, wr_word, rd_word;
  logic            wr_ok, rd_ok;
  ivl_uvm_even_parity_gen #(.WIDTH(WIDTH)) u_gen (.data(din), .word(gen_word));
`ifdef PARITY_FIFO_ERR_INJECT_EN
  assign wr_word = {gen_word[WIDTH] ^ err_inject, gen_word[WIDTH-1:0]};
`else
  assign wr_word = gen_word;
`endif
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  // a read frees a slot in the same cycle, so full still accepts a paired write
  assign wr_ok   = wn && (!full || rn);
  assign rd_ok   = rn && !empty;
  assign rd_word = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_ok && !reset) mem[wr_ptr] <= wr_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(wr_ok);
      rd_ptr     <= rd_ptr + AW'(rd_ok);
      count      <= count + CW'(wr_ok) - CW'(rd_ok);
      dout       <= rd_ok ? rd_word : dout;
      dout_valid <= rd_ok;
      overflow   <= overflow | (wn && !wr_ok);
      underflow  <= underflow | (rn && empty);
      parity_err <= parity_err | (rd_ok && even_par(PAR_MAX_W'(rd_word)));
    end
  end
endmodule

// File: tb/tb_ivl_uvm_parity_fifo.sv
// tb_ivl_uvm_parity_fifo: directed self-checking bench; exercises err_inject when PARITY_FIFO_ERR_INJECT_EN is defined
module tb_ivl_uvm_parity_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wn = 1'b0;
  logic       rn = 1'b0;
  logic [7:0] din = '0;
  logic       err_inject = 1'b0;
  logic [8:0] dout;
  logic       dout_valid, full, empty, overflow, underflow, parity_err;
  logic [2:0] count;
  int         n_cmp = 0;
  int         n_err = 0;
  ivl_uvm_parity_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wn(wn), .din(din),
`ifdef PARITY_FIFO_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .rn(rn), .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wn = 1'b1; din = d;
    tick();
    wn = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [8:0] exp);
    rn = 1'b1;
    tick();
    rn = 1'b0;
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_valid"}, 32'(dout_valid), 1);
  endtask
  initial begin
    repeat (5) tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_flags", {29'b0, overflow, underflow, parity_err}, 0);
    reset = 1'b0;
    tick();
    wr(8'h00); wr(8'h01); wr(8'h02); wr(8'h63);
    chk("ord_count", 32'(count), 4);
    chk("ord_full", 32'(full), 1);
    rd("ord0", 9'h000); rd("ord1", 9'h101); rd("ord2", 9'h102); rd("ord3", 9'h063);
    tick();
    chk("ord_valid_drop", 32'(dout_valid), 0);
    chk("ord_dout_hold", 32'(dout), 9'h063);
    chk("ord_empty", 32'(empty), 1);
    chk("ord_perr", 32'(parity_err), 0);
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    chk("ovf_pre", 32'(overflow), 0);
    wr(8'h55);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    rd("ovf0", 9'h011); rd("ovf1", 9'h022); rd("ovf2", 9'h033); rd("ovf3", 9'h044);
    chk("ovf_empty", 32'(empty), 1);
    rn = 1'b1;
    tick();
    rn = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_valid", 32'(dout_valid), 0);
    chk("unf_dout", 32'(dout), 9'h044);
    rn = 1'b1; wn = 1'b1; din = 8'h07;
    tick();
    rn = 1'b0; wn = 1'b0;
    chk("erw_count", 32'(count), 1);
    chk("erw_valid", 32'(dout_valid), 0);
    chk("erw_dout", 32'(dout), 9'h044);
    rd("erw_rd", 9'h107);
    wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    for (int i = 0; i < 3; i++) begin
      logic [8:0] exp_a [3];
      exp_a = '{9'h0A0, 9'h1A1, 9'h1A2};
      rn = 1'b1; wn = 1'b1; din = 8'hB0 + 8'(i);
      tick();
      chk("frw_dout", 32'(dout), 32'(exp_a[i]));
      chk("frw_valid", 32'(dout_valid), 1);
      chk("frw_count", 32'(count), 4);
      chk("frw_full", 32'(full), 1);
    end
    rn = 1'b0; wn = 1'b0;
    chk("frw_no_ovf_change", 32'(overflow), 1);
    rd("wrap0", 9'h0A3); rd("wrap1", 9'h1B0); rd("wrap2", 9'h0B1); rd("wrap3", 9'h0B2);
    chk("wrap_empty", 32'(empty), 1);
    chk("sticky_unf", 32'(underflow), 1);
    wr(8'h5A); wr(8'h3C);
    reset = 1'b1; wn = 1'b1; din = 8'hFF;
    tick();
    reset = 1'b0; wn = 1'b0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_dout", 32'(dout), 0);
    chk("mrst_flags", {29'b0, overflow, underflow, parity_err}, 0);
    wr(8'hC3);
    rd("mrst_rd", 9'h0C3);
`ifdef PARITY_FIFO_ERR_INJECT_EN
    err_inject = 1'b1;
    wr(8'h01);
    err_inject = 1'b0;
    chk("inj_perr_pre", 32'(parity_err), 0);
    rd("inj_rd", 9'h001);
    chk("inj_perr", 32'(parity_err), 1);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
